inference_scheduler: RTL and testbench
======================================

INFERENCE_SCHEDULER -- requirements
Module: inference_scheduler

Interface
REQ-001 Parameter N_OUT, default 10: number of output-layer neurons scanned for the class decision.
REQ-002 Parameter DATA_W, default 16: width of one signed output-neuron value.
REQ-003 Parameter TIMEOUT_CYC, default 4096: maximum cycles from Compute assertion to sequencer completion.
REQ-004 Clk  input  1  single clock; all logic on rising edge.
REQ-005 Reset_n  input  1  synchronous, active-low reset.
REQ-006 Start  input  1  host request pulse; sampled only in IDLE.
REQ-007 Compute  output  1  level request to the layer sequencer.
REQ-008 R  input  1  sequencer ready/idle flag: 1 in its idle/done states, 0 while running.
REQ-009 Out_idx  output  4  read index into the output-layer result registers.
REQ-010 Out_data  input  DATA_W  signed value at Out_idx, combinational (same-cycle) read.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Done  output  1  one-cycle pulse when Digit/Score are updated.
REQ-013 Digit  output  4  classified digit, or 4'hF after a timeout.
REQ-014 Score  output  DATA_W  signed winning output value.
REQ-015 Error  output  1  sticky timeout flag.

Function
REQ-016 The FSM SHALL have states IDLE, ARM, RUN, RELEASE, SCAN, REPORT, FAULT.
REQ-017 IDLE: Start=1 -> ARM, clear Error, clear timeout counter; Start in any other state SHALL be ignored.
REQ-018 ARM: Compute=1; R=0 -> RUN.
REQ-019 RUN: Compute=1; R=1 -> RELEASE.
REQ-020 RELEASE: Compute=0; R=1 for that cycle -> SCAN with Out_idx=0.
REQ-021 The timeout counter SHALL increment every cycle in ARM and RUN; reaching TIMEOUT_CYC-1 without the exit condition -> FAULT.
REQ-022 SCAN: one index per cycle, Out_idx 0..N_OUT-1; index 0 loads the running max unconditionally; later indices replace it only if Out_data > max (signed, strict), so ties keep the lowest index.
REQ-023 After index N_OUT-1 is evaluated -> REPORT; SCAN SHALL last exactly N_OUT cycles.
REQ-024 REPORT: register Digit=argmax and Score=max, Done=1 for exactly this cycle, -> IDLE.
REQ-025 FAULT: Compute=0, Error=1, Digit=4'hF, Score=0, Done=1 for one cycle, -> IDLE.
REQ-026 Start-to-Done latency SHALL be (ARM cycles)+(RUN cycles)+1+N_OUT+1.
REQ-027 Out_idx SHALL be 0 outside SCAN; Compute SHALL be 1 only in ARM and RUN.
REQ-028 Digit, Score and Error SHALL hold their values between reports.

Reset
REQ-029 Reset_n=0 at a clock edge SHALL force IDLE, Compute=0, Busy=0, Done=0, Out_idx=0, Digit=0, Score=0, Error=0, counter=0, from any state.
REQ-030 Reset mid-RUN SHALL drop Compute on the next cycle; no Done pulse SHALL follow.

Structure
REQ-031 The state enum and default N_OUT/DATA_W SHALL live in the shared nn_pkg package.
REQ-032 The running argmax SHALL be one sub-module, argmax_seq (init, valid, index, value -> best index, best value).
REQ-033 The block SHALL contain no multipliers or memories; comparison only.

Verification
REQ-034 Start pulse; sequencer model R 1->0 after 2 cycles, 0->1 after 850; outputs {3,-5,9,9,0,1,2,-8,4,7} -> Digit=2, Score=9, one Done, Error=0.
REQ-035 All outputs negative {-9,-3,-7,-4,-3,-10,-20,-5,-6,-8} -> Digit=1, Score=-3.
REQ-036 R held 0 forever after ARM -> FAULT at TIMEOUT_CYC, Digit=4'hF, Error=1, Compute=0; next Start clears Error.
REQ-037 Start pulses during RUN and SCAN -> ignored; exactly one Done per accepted Start.
REQ-038 Reset_n=0 mid-SCAN (Out_idx=5) -> next cycle IDLE, all outputs 0, no Done.
REQ-039 Two back-to-back runs (Start in cycle after Done) -> second result reported independently of first max.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and defaults for the inference scheduler
// Purpose: scheduler FSM state enum, default output-layer geometry and
//          timeout, index width shared by the scheduler and argmax_seq.
// Ports:   none (package).
package nn_pkg;

   localparam int N_OUT_DEF   = 10;
   localparam int DATA_W_DEF  = 16;
   localparam int TIMEOUT_DEF = 4096;
   localparam int IDX_W       = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      RUN     = 3'd2,
      RELEASE = 3'd3,
      SCAN    = 3'd4,
      REPORT  = 3'd5,
      FAULT   = 3'd6
   } sched_state_t;

endpackage

// File: rtl/argmax_seq.sv
// rtl/argmax_seq.sv - sequential running argmax over one value per cycle
// Purpose: tracks the index and value of the largest signed sample seen since
//          the last init; ties keep the earliest index.
// Ports:   Clk, Reset_n   - clock, synchronous active-low reset
//          init           - current sample restarts the search
//          valid          - current sample takes part in the search
//          index, value   - sample position and signed sample
//          best_idx/val   - best so far, already including the current sample
module argmax_seq
   import nn_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     init,
   input  logic                     valid,
   input  logic [IDX_W-1:0]         index,
   input  logic signed [DATA_W-1:0] value,
   output logic [IDX_W-1:0]         best_idx,
   output logic signed [DATA_W-1:0] best_val
);

   logic [IDX_W-1:0]         run_idx;
   logic signed [DATA_W-1:0] run_val;
   logic                     take;

   // Outputs include the current sample so the caller can capture the final
   // result on the same edge that evaluates the last index.
   always_comb begin
      take     = valid && (init || (value > run_val));
      best_idx = take ? index : run_idx;
      best_val = take ? value : run_val;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         run_idx <= '0;
         run_val <= '0;
      end else begin
         run_idx <= best_idx;
         run_val <= best_val;
      end
   end

endmodule

// File: rtl/inference_scheduler.sv
// rtl/inference_scheduler.sv - runs the layer sequencer then picks the winning class
// Purpose: on Start, requests a network pass (Compute) from the layer
//          sequencer, waits for it to finish (R), scans the output layer for
//          the signed maximum and reports digit/score; a timeout reports a fault.
// Ports:   Clk, Reset_n   - clock, synchronous active-low reset
//          Start          - host request pulse (honoured only when idle)
//          Compute, R     - level request to / ready flag from the sequencer
//          Out_idx        - read index into output-layer results
//          Out_data       - signed result at Out_idx (same-cycle read)
//          Busy, Done     - not idle / one-cycle result-update pulse
//          Digit, Score   - winning class (4'hF on fault) and its value
//          Error          - sticky timeout flag, cleared by the next Start
module inference_scheduler
   import nn_pkg::*;
#(
   parameter int N_OUT       = N_OUT_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic                     Start,
   output logic                     Compute,
   input  logic                     R,
   output logic [IDX_W-1:0]         Out_idx,
   input  logic signed [DATA_W-1:0] Out_data,
   output logic                     Busy,
   output logic                     Done,
   output logic [IDX_W-1:0]         Digit,
   output logic signed [DATA_W-1:0] Score,
   output logic                     Error
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   sched_state_t             state, state_next;
   logic [CNT_W-1:0]         tmo_cnt;
   logic [IDX_W-1:0]         scan_idx;
   logic                     timeout_hit;
   logic                     scan_last;
   logic [IDX_W-1:0]         best_idx;
   logic signed [DATA_W-1:0] best_val;

   assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign scan_last   = (scan_idx == IDX_W'(N_OUT - 1));

   // State register
   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state logic; the sequencer exit condition wins over a timeout
   // landing on the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (Start) state_next = ARM;
         ARM:     if (!R) state_next = RUN;
                  else if (timeout_hit) state_next = FAULT;
         RUN:     if (R) state_next = RELEASE;
                  else if (timeout_hit) state_next = FAULT;
         // A sequencer that drops R again after release is waited on again
         // under timeout protection rather than scanned mid-update.
         RELEASE: state_next = R ? SCAN : RUN;
         SCAN:    if (scan_last) state_next = REPORT;
         REPORT:  state_next = IDLE;
         FAULT:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      Compute = (state == ARM) || (state == RUN);
      Busy    = (state != IDLE);
      Done    = (state == REPORT) || (state == FAULT);
      Out_idx = (state == SCAN) ? scan_idx : '0;
   end

   // Datapath: timeout counter, scan index and the held result registers.
   // Results are captured on the edge entering REPORT/FAULT so they are
   // already valid while Done is high.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         tmo_cnt  <= '0;
         scan_idx <= '0;
         Digit    <= '0;
         Score    <= '0;
         Error    <= 1'b0;
      end else begin
         if (state == IDLE && Start)
            tmo_cnt <= '0;
         else if (state == ARM || state == RUN)
            tmo_cnt <= tmo_cnt + CNT_W'(1);

         scan_idx <= (state == SCAN) ? scan_idx + IDX_W'(1) : '0;

         if (state == IDLE && Start)
            Error <= 1'b0;

         if (state_next == FAULT && state != FAULT) begin
            Error <= 1'b1;
            Digit <= 4'hF;
            Score <= '0;
         end

         if (state == SCAN && scan_last) begin
            Digit <= best_idx;
            Score <= best_val;
         end
      end
   end

   argmax_seq #(
      .DATA_W (DATA_W)
   ) u_argmax (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .init     ((state == SCAN) && (scan_idx == '0)),
      .valid    (state == SCAN),
      .index    (scan_idx),
      .value    (Out_data),
      .best_idx (best_idx),
      .best_val (best_val)
   );

endmodule

// File: tb/tb_inference_scheduler.sv
// tb/tb_inference_scheduler.sv - self-checking bench for inference_scheduler
module tb_inference_scheduler;

   localparam int N_OUT       = 10;
   localparam int DATA_W      = 16;
   localparam int TIMEOUT_CYC = 4096;
   localparam int NV          = 7;

   logic                     Clk = 1'b0;
   logic                     Reset_n;
   logic                     Start;
   logic                     Compute;
   logic                     R;
   logic [3:0]               Out_idx;
   logic signed [DATA_W-1:0] Out_data;
   logic                     Busy;
   logic                     Done;
   logic [3:0]               Digit;
   logic signed [DATA_W-1:0] Score;
   logic                     Error;

   typedef struct {
      int v [N_OUT];
      int go;
      int run;
      bit poke;
      bit b2b;
      int digit;
      int score;
   } vec_t;

   typedef struct {
      int digit;
      int score;
      int error;
   } exp_t;

   vec_t tbl [NV];
   exp_t exp_q [$];
   int   cur_v [N_OUT];
   int   total = 0;
   int   bad   = 0;

   always #5 Clk = ~Clk;

   // Output-layer result registers as seen by the scheduler (same-cycle read)
   always_comb begin
      Out_data = '0;
      if (int'(Out_idx) < N_OUT) Out_data = DATA_W'(cur_v[int'(Out_idx)]);
   end

   inference_scheduler #(
      .N_OUT       (N_OUT),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .Compute  (Compute),
      .R        (R),
      .Out_idx  (Out_idx),
      .Out_data (Out_data),
      .Busy     (Busy),
      .Done     (Done),
      .Digit    (Digit),
      .Score    (Score),
      .Error    (Error)
   );

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // One accepted run. Called at a negedge while idle. The sequencer model
   // holds R=1 for go cycles after Start is taken, R=0 for run cycles, then 1.
   task automatic run_one(input int go, input int run, input bit poke,
                          input bit fault, input exp_t e);
      int k, busy_n, trace_err, s0, exp_busy;
      bit fin, exp_c;
      int exp_i;
      exp_t got;
      exp_q.push_back(e);
      Start = 1'b1;
      R     = 1'b1;
      @(negedge Clk);
      Start     = 1'b0;
      k         = 1;
      fin       = 1'b0;
      busy_n    = 0;
      trace_err = 0;
      s0        = go + run + 3;
      exp_busy  = fault ? TIMEOUT_CYC + 1 : go + run + 3 + N_OUT;
      while (!fin && k < 6000) begin
         R = (k > go && k <= go + run) ? 1'b0 : 1'b1;
         if (poke) Start = (k % 5 == 2);
         if (fault) begin
            exp_c = (k <= TIMEOUT_CYC);
            exp_i = 0;
         end else begin
            exp_c = (k <= go + 1 + run);
            exp_i = (k >= s0 && k < s0 + N_OUT) ? k - s0 : 0;
         end
         if (Compute !== exp_c || int'(Out_idx) != exp_i) trace_err++;
         if (Busy) busy_n++;
         if (Done) begin
            fin = 1'b1;
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 1, 0);
            end else begin
               got = exp_q.pop_front();
               check("digit", int'(Digit), got.digit);
               check("score", int'(Score), got.score);
               check("error", int'(Error), got.error);
            end
            if (fault) check("fault_compute", int'(Compute), 0);
         end
         @(negedge Clk);
         k++;
      end
      Start = 1'b0;
      R     = 1'b1;
      check("done_seen", int'(fin), 1);
      check("busy_cycles", busy_n, exp_busy);
      check("compute_idx_trace", trace_err, 0);
   endtask

   initial begin
      exp_t e;
      int   extra, k;
      bit   seen;

      tbl[0].v = '{3, -5, 9, 9, 0, 1, 2, -8, 4, 7};
      tbl[0].go = 2; tbl[0].run = 850; tbl[0].poke = 0; tbl[0].b2b = 0;
      tbl[0].digit = 2; tbl[0].score = 9;
      tbl[1].v = '{-9, -3, -7, -4, -3, -10, -20, -5, -6, -8};
      tbl[1].go = 1; tbl[1].run = 20; tbl[1].poke = 1; tbl[1].b2b = 0;
      tbl[1].digit = 1; tbl[1].score = -3;
      tbl[2].v = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 32767};
      tbl[2].go = 0; tbl[2].run = 1; tbl[2].poke = 0; tbl[2].b2b = 0;
      tbl[2].digit = 9; tbl[2].score = 32767;
      tbl[3].v = '{-32768, -32768, -32768, -32768, -32768,
                   -32768, -32768, -32768, -32768, -32768};
      tbl[3].go = 1; tbl[3].run = 2; tbl[3].poke = 0; tbl[3].b2b = 0;
      tbl[3].digit = 0; tbl[3].score = -32768;
      tbl[4].v = '{500, 499, -1, 0, 499, 12, 500, 3, 2, 1};
      tbl[4].go = 3; tbl[4].run = 5; tbl[4].poke = 1; tbl[4].b2b = 0;
      tbl[4].digit = 0; tbl[4].score = 500;
      tbl[5].v = '{50, 40, 30, 20, 10, 0, -10, -20, -30, 100};
      tbl[5].go = 0; tbl[5].run = 4; tbl[5].poke = 0; tbl[5].b2b = 0;
      tbl[5].digit = 9; tbl[5].score = 100;
      tbl[6].v = '{7, 8, 9, 1, 2, 3, 4, 5, 6, 0};
      tbl[6].go = 1; tbl[6].run = 3; tbl[6].poke = 0; tbl[6].b2b = 1;
      tbl[6].digit = 2; tbl[6].score = 9;

      cur_v   = tbl[0].v;
      Reset_n = 1'b0;
      Start   = 1'b0;
      R       = 1'b1;
      repeat (3) @(negedge Clk);
      check("rst_busy", int'(Busy), 0);
      check("rst_done", int'(Done), 0);
      check("rst_compute", int'(Compute), 0);
      check("rst_out_idx", int'(Out_idx), 0);
      check("rst_digit", int'(Digit), 0);
      check("rst_score", int'(Score), 0);
      check("rst_error", int'(Error), 0);
      Reset_n = 1'b1;
      @(negedge Clk);

      for (int i = 0; i < NV; i++) begin
         e.digit = tbl[i].digit;
         e.score = tbl[i].score;
         e.error = 0;
         cur_v   = tbl[i].v;
         run_one(tbl[i].go, tbl[i].run, tbl[i].poke, 1'b0, e);
         if (i == NV - 1 || !tbl[(i + 1) % NV].b2b) begin
            extra = 0;
            repeat (4) begin
               if (Done || Busy) extra++;
               @(negedge Clk);
            end
            check("no_extra_run", extra, 0);
            check("hold_digit", int'(Digit), tbl[i].digit);
            check("hold_score", int'(Score), tbl[i].score);
         end
      end

      // Sequencer never finishes: timeout fault
      e = '{15, 0, 1};
      run_one(0, 1000000, 1'b0, 1'b1, e);
      repeat (3) @(negedge Clk);
      check("error_sticky", int'(Error), 1);
      check("fault_digit_hold", int'(Digit), 15);
      check("fault_idle", int'(Busy), 0);

      // Next Start clears Error
      e.digit = tbl[2].digit;
      e.score = tbl[2].score;
      e.error = 0;
      cur_v   = tbl[2].v;
      run_one(tbl[2].go, tbl[2].run, 1'b0, 1'b0, e);
      @(negedge Clk);

      // Reset in the middle of SCAN at Out_idx=5
      cur_v = tbl[0].v;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      k     = 1;
      seen  = 1'b0;
      while (!seen && k < 200) begin
         R = (k > 1 && k <= 4) ? 1'b0 : 1'b1;
         if (Out_idx == 4'd5) seen = 1'b1;
         else begin
            @(negedge Clk);
            k++;
         end
      end
      check("reached_idx5", int'(seen), 1);
      Reset_n = 1'b0;
      @(negedge Clk);
      check("scan_rst_busy", int'(Busy), 0);
      check("scan_rst_done", int'(Done), 0);
      check("scan_rst_out_idx", int'(Out_idx), 0);
      check("scan_rst_digit", int'(Digit), 0);
      check("scan_rst_score", int'(Score), 0);
      check("scan_rst_error", int'(Error), 0);
      Reset_n = 1'b1;
      R       = 1'b1;
      extra   = 0;
      repeat (20) begin
         if (Done) extra++;
         @(negedge Clk);
      end
      check("no_done_after_scan_rst", extra, 0);

      // Reset in the middle of RUN drops Compute next cycle
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      R     = 1'b0;
      repeat (5) @(negedge Clk);
      check("run_compute_high", int'(Compute), 1);
      Reset_n = 1'b0;
      @(negedge Clk);
      check("run_rst_compute", int'(Compute), 0);
      check("run_rst_busy", int'(Busy), 0);
      Reset_n = 1'b1;
      R       = 1'b1;
      extra   = 0;
      repeat (20) begin
         if (Done) extra++;
         @(negedge Clk);
      end
      check("no_done_after_run_rst", extra, 0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
